// File: rtl/seg7_pkg.sv
// Shared types, segment decode table and decode helper for the 7-segment scan driver.
package seg7_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_e;

    // Logical-on segment patterns {g,f,e,d,c,b,a}; codes 10..15 are dark.
    localparam seg_t SEG_LUT [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b0000000, 7'b0000000,
        7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
    };

    function automatic seg_t bcd_to_seg(input bcd_t b);
        return SEG_LUT[b];
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder; output is logical-on, polarity handled by the caller.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  bcd_t bcd,
    output seg_t seg
);

    // Table lookup of the segment pattern.
    always_comb begin
        seg = bcd_to_seg(bcd);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver: per-frame digit snapshot, guard blanking between slots,
// leading-zero blanking and a frame-done strobe. All outputs are registered.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIG    = 2,
    parameter int SCAN_DIV   = 1000,
    parameter int GUARD      = 1,
    parameter int ACTIVE_LOW = 1,
    parameter int LZ_BLANK   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  bcd_t [NUM_DIG-1:0]       digits,
    input  logic [NUM_DIG-1:0]       dp_mask,
    output logic [6:0]               seg,
    output logic                     dp,
    output logic [NUM_DIG-1:0]       an,
    output logic                     frame_done
);

    localparam int IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam int CNT_W = $clog2(SCAN_DIV + 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIG - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD > 0) ? (GUARD - 1) : 0);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - GUARD - 1);
    localparam scan_state_e      SLOT_START = (GUARD > 0) ? BLANK : SHOW;
    localparam logic             POL        = (ACTIVE_LOW != 0);

    scan_state_e              state_r, state_n_s;
    logic [IDX_W-1:0]         idx_r, idx_n_s;
    logic [CNT_W-1:0]         cnt_r, cnt_n_s;
    bcd_t [NUM_DIG-1:0]       snap_r, snap_n_s;
    logic [NUM_DIG-1:0]       snap_dp_r, snap_dp_n_s;
    logic                     frame_end_s;
    logic                     lz_blank_s;
    seg_t                     dec_seg_s;
    seg_t                     seg_on_s;
    logic                     dp_on_s;
    logic [NUM_DIG-1:0]       an_on_s;

    // Next-state logic: prescaled slot timing, digit index advance and frame snapshot.
    always_comb begin
        state_n_s   = state_r;
        idx_n_s     = idx_r;
        cnt_n_s     = cnt_r;
        snap_n_s    = snap_r;
        snap_dp_n_s = snap_dp_r;
        frame_end_s = 1'b0;
        if (!en) begin
            state_n_s = IDLE;
            idx_n_s   = '0;
            cnt_n_s   = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    snap_n_s    = digits;
                    snap_dp_n_s = dp_mask;
                    idx_n_s     = '0;
                    cnt_n_s     = '0;
                    state_n_s   = SLOT_START;
                end
                BLANK: begin
                    if (cnt_r == GUARD_LAST) begin
                        state_n_s = SHOW;
                        cnt_n_s   = '0;
                    end else begin
                        cnt_n_s = cnt_r + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (cnt_r == SHOW_LAST) begin
                        cnt_n_s   = '0;
                        state_n_s = SLOT_START;
                        if (idx_r == IDX_LAST) begin
                            idx_n_s     = '0;
                            frame_end_s = 1'b1;
                            snap_n_s    = digits;
                            snap_dp_n_s = dp_mask;
                        end else begin
                            idx_n_s = idx_r + IDX_W'(1);
                        end
                    end else begin
                        cnt_n_s = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_n_s = IDLE;
                    idx_n_s   = '0;
                    cnt_n_s   = '0;
                end
            endcase
        end
    end

    bcd_to_seg7 u_dec (
        .bcd (snap_n_s[idx_n_s]),
        .seg (dec_seg_s)
    );

    // Output values for the upcoming cycle, so registered outputs line up with the state.
    always_comb begin
        lz_blank_s = (LZ_BLANK != 0) && (idx_n_s != '0);
        for (int k = 0; k < NUM_DIG; k++) begin
            lz_blank_s = lz_blank_s && !((k >= int'(idx_n_s)) && (snap_n_s[k] != 4'd0));
        end
        if (state_n_s == SHOW) begin
            an_on_s  = NUM_DIG'(1) << idx_n_s;
            dp_on_s  = snap_dp_n_s[idx_n_s];
            seg_on_s = lz_blank_s ? 7'd0 : dec_seg_s;
        end else begin
            an_on_s  = '0;
            dp_on_s  = 1'b0;
            seg_on_s = 7'd0;
        end
    end

    // State and registered outputs with pin polarity applied.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            idx_r      <= '0;
            cnt_r      <= '0;
            snap_r     <= '0;
            snap_dp_r  <= '0;
            seg        <= {7{POL}};
            dp         <= POL;
            an         <= {NUM_DIG{POL}};
            frame_done <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            idx_r      <= idx_n_s;
            cnt_r      <= cnt_n_s;
            snap_r     <= snap_n_s;
            snap_dp_r  <= snap_dp_n_s;
            seg        <= seg_on_s ^ {7{POL}};
            dp         <= dp_on_s ^ POL;
            an         <= an_on_s ^ {NUM_DIG{POL}};
            frame_done <= frame_end_s;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench: three driver configurations share one stimulus stream and are
// compared every cycle against a frame-position model, plus hand-computed spot checks.
module tb_seg7_scan_driver;

    localparam int ND    = 2;
    localparam int SD    = 4;
    localparam int G     = 1;
    localparam int FRAME = ND * SD;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [1:0][3:0] digits;
    logic [1:0]      dp_mask;

    logic [6:0] seg_a, seg_b, seg_c;
    logic       dp_a, dp_b, dp_c;
    logic [1:0] an_a, an_b, an_c;
    logic       fd_a, fd_b, fd_c;

    seg7_scan_driver #(.NUM_DIG(ND), .SCAN_DIV(SD), .GUARD(G), .ACTIVE_LOW(0), .LZ_BLANK(0)) dut_a (
        .clk(clk), .rst(rst), .en(en), .digits(digits), .dp_mask(dp_mask),
        .seg(seg_a), .dp(dp_a), .an(an_a), .frame_done(fd_a));
    seg7_scan_driver #(.NUM_DIG(ND), .SCAN_DIV(SD), .GUARD(G), .ACTIVE_LOW(0), .LZ_BLANK(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .digits(digits), .dp_mask(dp_mask),
        .seg(seg_b), .dp(dp_b), .an(an_b), .frame_done(fd_b));
    seg7_scan_driver #(.NUM_DIG(ND), .SCAN_DIV(SD), .GUARD(G), .ACTIVE_LOW(1), .LZ_BLANK(1)) dut_c (
        .clk(clk), .rst(rst), .en(en), .digits(digits), .dp_mask(dp_mask),
        .seg(seg_c), .dp(dp_c), .an(an_c), .frame_done(fd_c));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    bit              m_active = 1'b0;
    int              m_t = 0;
    logic [1:0][3:0] m_snap = '0;
    logic [1:0]      m_dp = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] dec(input logic [3:0] v);
        case (v)
            4'd0: return 7'b0111111;
            4'd1: return 7'b0000110;
            4'd2: return 7'b1011011;
            4'd3: return 7'b1001111;
            4'd4: return 7'b1100110;
            4'd5: return 7'b1101101;
            4'd6: return 7'b1111101;
            4'd7: return 7'b0000111;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    // Expected pins from the position within the frame since enable.
    task automatic model_out(input bit al, input bit lz, output logic [1:0] an,
                             output logic [6:0] sg, output logic d, output logic fd);
        int  p, slot, off;
        bit  zeros;
        an = 2'b00; sg = 7'd0; d = 1'b0;
        fd = m_active && (m_t > 0) && (m_t % FRAME == 0);
        if (m_active) begin
            p = m_t % FRAME; slot = p / SD; off = p % SD;
            if (off >= G) begin
                an = 2'(1 << slot);
                sg = dec(m_snap[slot]);
                d  = m_dp[slot];
                if (lz && slot > 0) begin
                    zeros = 1'b1;
                    for (int j = slot; j < ND; j++) if (m_snap[j] != 4'd0) zeros = 1'b0;
                    if (zeros) sg = 7'd0;
                end
            end
        end
        if (al) begin an = ~an; sg = ~sg; d = ~d; end
    endtask

    // Model update at each edge and per-cycle comparison of all three instances.
    initial begin
        logic [1:0] e_an;
        logic [6:0] e_sg;
        logic       e_dp, e_fd;
        forever begin
            @(posedge clk);
            if (rst || !en) begin
                m_active = 1'b0;
            end else if (!m_active) begin
                m_active = 1'b1; m_t = 0; m_snap = digits; m_dp = dp_mask;
            end else begin
                m_t++;
                if (m_t % FRAME == 0) begin m_snap = digits; m_dp = dp_mask; end
            end
            #1;
            model_out(1'b0, 1'b0, e_an, e_sg, e_dp, e_fd);
            chk("a_an", 32'(an_a), 32'(e_an)); chk("a_seg", 32'(seg_a), 32'(e_sg));
            chk("a_dp", 32'(dp_a), 32'(e_dp)); chk("a_fd", 32'(fd_a), 32'(e_fd));
            model_out(1'b0, 1'b1, e_an, e_sg, e_dp, e_fd);
            chk("b_an", 32'(an_b), 32'(e_an)); chk("b_seg", 32'(seg_b), 32'(e_sg));
            chk("b_dp", 32'(dp_b), 32'(e_dp)); chk("b_fd", 32'(fd_b), 32'(e_fd));
            model_out(1'b1, 1'b1, e_an, e_sg, e_dp, e_fd);
            chk("c_an", 32'(an_c), 32'(e_an)); chk("c_seg", 32'(seg_c), 32'(e_sg));
            chk("c_dp", 32'(dp_c), 32'(e_dp)); chk("c_fd", 32'(fd_c), 32'(e_fd));
        end
    end

    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Restart scanning with fresh digits; returns at frame position 0.
    task automatic start(input logic [3:0] d1, input logic [3:0] d0, input logic [1:0] dpm);
        @(negedge clk);
        en = 1'b0; digits[1] = d1; digits[0] = d0; dp_mask = dpm;
        @(negedge clk);
        en = 1'b1;
        go(1);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; digits = '0; dp_mask = 2'b00;
        go(3);
        chk("rst_a_an", 32'(an_a), 32'h0);
        chk("rst_a_fd", 32'(fd_a), 32'h0);
        chk("rst_c_an", 32'(an_c), 32'h3);
        chk("rst_c_seg", 32'(seg_c), 32'h7f);
        chk("rst_c_dp", 32'(dp_c), 32'h1);
        @(negedge clk); rst = 1'b0;
        go(2);

        start(4'd3, 4'd7, 2'b00);
        chk("t1_p0_an", 32'(an_a), 32'h0);
        go(1); chk("t1_p1_an", 32'(an_a), 32'h1); chk("t1_p1_seg", 32'(seg_a), 32'b0000111);
        go(4); chk("t1_p5_an", 32'(an_a), 32'h2); chk("t1_p5_seg", 32'(seg_a), 32'b1001111);
        go(3); chk("t1_p8_fd", 32'(fd_a), 32'h1); chk("t1_p8_an", 32'(an_a), 32'h0);
        go(9);

        start(4'd0, 4'd5, 2'b00);
        go(1); chk("lz_p1_seg", 32'(seg_b), 32'b1101101);
        go(4); chk("lz_p5_an", 32'(an_b), 32'h2); chk("lz_p5_seg", 32'(seg_b), 32'h0);
        start(4'd0, 4'd0, 2'b00);
        go(1); chk("lz00_p1_seg", 32'(seg_b), 32'b0111111);
        go(4); chk("lz00_p5_seg", 32'(seg_b), 32'h0);

        start(4'd1, 4'd2, 2'b00);
        go(1); chk("snap_p1_seg", 32'(seg_a), 32'b1011011);
        @(negedge clk); digits[1] = 4'd4; digits[0] = 4'd9;
        go(4); chk("snap_p5_seg", 32'(seg_a), 32'b0000110);
        go(4); chk("snap_p9_seg", 32'(seg_a), 32'b1101111);
        go(4); chk("snap_p13_seg", 32'(seg_a), 32'b1100110);

        go(5);
        @(negedge clk); en = 1'b0;
        go(1); chk("drop_an", 32'(an_a), 32'h0); chk("drop_seg", 32'(seg_a), 32'h0);
        chk("drop_fd", 32'(fd_a), 32'h0);
        go(3);
        @(negedge clk); en = 1'b1;
        go(1); chk("reen_p0_an", 32'(an_a), 32'h0);
        go(1); chk("reen_p1_an", 32'(an_a), 32'h1);
        go(10);

        start(4'd0, 4'd12, 2'b01);
        go(1); chk("al_seg", 32'(seg_c), 32'h7f); chk("al_dp", 32'(dp_c), 32'h0);
        chk("al_an", 32'(an_c), 32'h2); chk("ah_dp", 32'(dp_a), 32'h1);
        go(4); chk("rstm_p5_an", 32'(an_a), 32'h2);
        @(negedge clk); rst = 1'b1;
        go(1); chk("rstm_an", 32'(an_a), 32'h0); chk("rstm_seg", 32'(seg_a), 32'h0);
        chk("rstm_fd", 32'(fd_a), 32'h0); chk("rstm_c_an", 32'(an_c), 32'h3);
        @(negedge clk); rst = 1'b0; digits[1] = 4'd8; digits[0] = 4'd6; dp_mask = 2'b10;
        go(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
